// File: rtl/alu_cmd_issue.sv
// ----------------------------------------------------------------------------
// alu_cmd_issue
//   Issue stage in front of a 4-bit combinational ALU. Commands (a, b, op)
//   are accepted over a valid/ready handshake into a DEPTH-entry FIFO. The
//   head entry drives the ALU inputs. The ALU result and zero flag are then
//   captured into an output register, which is offered downstream over a
//   second valid/ready handshake. A saturating counter tracks how many
//   results the downstream side has consumed.
//
// Handshake rule (both ports): a transfer happens on the rising clk edge
//   where valid && ready are both high. The source holds valid and its data
//   stable until that transfer. Dropping valid without a transfer is legal
//   on the input side.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     command handshake; in_a, in_b, in_op = command
//   alu_a/alu_b/alu_op    head command to the ALU (zeros when FIFO empty)
//   alu_result/alu_zero   combinational ALU response
//   out_valid/out_ready   result handshake; out_result, out_zero, out_op
//   level                 FIFO occupancy (0..DEPTH)
//   done_cnt              saturating count of consumed results
// ----------------------------------------------------------------------------
module alu_cmd_issue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_a,
  input  logic [3:0]                 in_b,
  input  logic [1:0]                 in_op,
  output logic [3:0]                 alu_a,
  output logic [3:0]                 alu_b,
  output logic [1:0]                 alu_op,
  input  logic [3:0]                 alu_result,
  input  logic                       alu_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_result,
  output logic                       out_zero,
  output logic [1:0]                 out_op,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           done_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Each entry packs {op, b, a}.
  logic [9:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [9:0]    head;

  logic full;
  logic empty;
  logic push;
  logic fire;
  logic consume;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  // Gated by rst_n so the stage never advertises ready while held in reset.
  // Ready depends on level only: a full FIFO refuses a push even when the
  // head is popped in the same cycle.
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;
  assign fire     = !empty && (!out_valid || out_ready);
  assign consume  = out_valid && out_ready;
  assign level    = level_q;

  // Storage holds data only; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_op, in_b, in_a};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      // DEPTH is a power of 2, so the natural pointer rollover is modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (fire) rd_ptr <= rd_ptr + PW'(1);
      case ({push, fire})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_comb begin
    head   = mem[rd_ptr];
    alu_a  = 4'h0;
    alu_b  = 4'h0;
    alu_op = 2'b00;
    if (!empty) begin
      alu_a  = head[3:0];
      alu_b  = head[7:4];
      alu_op = head[9:8];
    end
  end

  // Output register. A fire always wins over a plain consume, so a
  // consume+fire cycle replaces the result and out_valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= 4'h0;
      out_zero   <= 1'b0;
      out_op     <= 2'b00;
    end else if (fire) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_zero   <= alu_zero;
      out_op     <= head[9:8];
    end else if (consume) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (consume && (done_cnt != '1)) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/alu_cmd_issue.md
Name: alu_cmd_issue

Overview:
- Upstream issue stage for the 4-bit combinational ALU.
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the head command onto the ALU inputs, captures the ALU result and zero flag into an output register, and presents them downstream over a second valid/ready handshake.
- Also keeps a saturating completion counter for bench and debug visibility.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- CNT_W, 8, width of the completion counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream command valid.
- in_ready  output  1  stage can accept a command.
- in_a  input  4  operand A.
- in_b  input  4  operand B.
- in_op  input  2  opcode: 00 add, 01 sub, 10 and, 11 or.
- alu_a  output  4  to ALU operand A.
- alu_b  output  4  to ALU operand B.
- alu_op  output  2  to ALU opcode.
- alu_result  input  4  from ALU result.
- alu_zero  input  1  from ALU zero flag.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_result  output  4  registered ALU result.
- out_zero  output  1  registered zero flag.
- out_op  output  2  opcode that produced out_result.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- done_cnt  output  CNT_W  count of results consumed downstream, saturating.

Behaviour:
- Reset: clk, one clock domain; rst_n is asynchronous and active-low. On rst_n low:
  - Immediately clear the FIFO pointers, level, out_valid, out_result, out_zero, out_op and done_cnt to 0.
  - in_ready goes low while rst_n is low and is 1 from the first cycle after release.
  - No partial command survives reset. A command or result in flight at reset is discarded, with no handshake completion reported.
- Input handshake:
  - Push on a rising edge when in_valid && in_ready.
  - in_ready = !full, decided combinationally from level only. There is no pass-through when the FIFO is full, even if a pop occurs in the same cycle.
- ALU drive:
  - When the FIFO is non-empty, alu_a/alu_b/alu_op show the head entry combinationally from storage.
  - When the FIFO is empty, they drive 0/0/00.
  - These outputs do not depend on in_* in the same cycle.
- Issue/capture (the fire condition is fire = !empty && (!out_valid || out_ready)):
  - On fire: pop the head, load out_result<=alu_result, out_zero<=alu_zero, out_op<=head op, and set out_valid<=1.
- Output handshake:
  - A result is consumed on a rising edge where out_valid && out_ready.
  - If it is consumed without a fire in the same cycle, out_valid<=0.
  - Consume and fire in the same cycle replaces the output register with the next result, and out_valid stays 1.
  - While out_valid && !out_ready, out_result/out_zero/out_op hold stable.
- Latency:
  - A command pushed at edge E0 into an empty stage with an idle output is visible on alu_* after E0 and on out_* after E1, so the result appears one cycle after acceptance.
  - Sustained throughput is 1 command/cycle when out_ready=1.
- Occupancy:
  - level increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
  - Maximum commands held is DEPTH in the FIFO plus 1 in the output register.
- Pointers:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - full = (level==DEPTH), empty = (level==0).
- done_cnt increments on each output consumption and saturates at all-ones; it does not wrap.
- Arithmetic: the ALU itself performs all arithmetic; this block does none. Results are 4-bit modulo, and no carry or borrow is reported.
- Protocol:
  - An in_valid that drops without a handshake is legal.
  - in_* are sampled only on push.

Test Plan:
1. Reset, then push (a=9, b=7, op=00) with out_ready=1 -> out_valid high one cycle after the push, out_result=0, out_zero=1, out_op=00, done_cnt=1.
2. Push (3, 5, 01) then (12, 10, 10) back-to-back -> consecutive results 4'hE (zero=0) then 4'h8 (zero=0); out_valid continuously high for 2 cycles.
3. Hold out_ready=0 with DEPTH=4 and offer 6 commands -> 5 accepted, in_ready low thereafter, level=4; out_* hold the first result stable. Raise out_ready -> all 5 results drain in order, level returns to 0, in_ready high.
4. Full-FIFO pop and push in the same cycle -> no push that cycle (in_ready=0); level goes 4->3 and the command is accepted the next cycle.
5. Push 10 commands through DEPTH=4 at full rate -> pointers wrap correctly, results match ALU reference order, level never exceeds 4.
6. Assert rst_n low mid-stream with level=3 and out_valid=1 -> outputs clear immediately and done_cnt=0. After release, a new push (15, 1, 11) yields out_result=4'hF, zero=0.
7. With CNT_W=2, consume 5 results -> done_cnt saturates at 3.
